// File: rtl/key_cond_pkg.sv
// Shared types and constant helpers for the key debounce conditioner.
package key_cond_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      FIRE,
      WAIT_REL
   } lp_state_t;

   // Released (inactive) level of a key pin.
   function automatic logic inactive_level(input int active_low);
      return (active_low != 0) ? 1'b1 : 1'b0;
   endfunction

   // Width of a counter that runs 0 .. n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key channel: two-flop synchroniser, stability counter, debounced level
// and one-cycle press/release pulses.
module debounce_channel
   import key_cond_pkg::*;
#(
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic level_next,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic          IDLE_LVL = inactive_level(ACTIVE_LOW);

   logic          sync1_reg, sync2_reg, stable_reg;
   logic          press_reg, release_reg;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          stable_next, press_next, release_next;

   always_comb begin
      cnt_next     = cnt_reg;
      stable_next  = stable_reg;
      press_next   = 1'b0;
      release_next = 1'b0;
      if (sync2_reg == stable_reg) begin
         cnt_next = '0;
      end else if (cnt_reg == CNT_LAST) begin
         cnt_next     = '0;
         stable_next  = sync2_reg;
         press_next   = (sync2_reg != IDLE_LVL);
         release_next = (sync2_reg == IDLE_LVL);
      end else begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg   <= IDLE_LVL;
         sync2_reg   <= IDLE_LVL;
         stable_reg  <= IDLE_LVL;
         cnt_reg     <= '0;
         press_reg   <= 1'b0;
         release_reg <= 1'b0;
      end else begin
         sync1_reg   <= raw;
         sync2_reg   <= sync1_reg;
         stable_reg  <= stable_next;
         cnt_reg     <= cnt_next;
         press_reg   <= press_next;
         release_reg <= release_next;
      end
   end

   assign level         = stable_reg;
   assign level_next    = stable_next;
   assign press_pulse   = press_reg;
   assign release_pulse = release_reg;

endmodule

// File: rtl/key_debounce_conditioner.sv
// Debounces the push-buttons for the button PIO and turns a long press on one
// key into a timed, active-low HPS warm-reset request.
module key_debounce_conditioner
   import key_cond_pkg::*;
#(
   parameter int WIDTH             = 4,
   parameter int ACTIVE_LOW        = 1,
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int LONG_PRESS_CYCLES = 150000000,
   parameter int LP_CHANNEL        = 0,
   parameter int REQ_PULSE_CYCLES  = 16
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [WIDTH-1:0] key_raw,
   output logic [WIDTH-1:0] key_level,
   output logic [WIDTH-1:0] key_press_pulse,
   output logic [WIDTH-1:0] key_release_pulse,
   output logic             lp_holding,
   output logic             warm_reset_req_n
);

   localparam int               LW       = cnt_width(LONG_PRESS_CYCLES);
   localparam int               PW       = cnt_width(REQ_PULSE_CYCLES);
   localparam logic [LW-1:0]    LP_LAST  = LW'(LONG_PRESS_CYCLES - 1);
   localparam logic [PW-1:0]    PC_LAST  = PW'(REQ_PULSE_CYCLES - 1);
   localparam logic             IDLE_LVL = inactive_level(ACTIVE_LOW);
   localparam logic [WIDTH-1:0] LP_MASK  = WIDTH'(1) << LP_CHANNEL;

   logic [WIDTH-1:0] level_next;
   logic [WIDTH-1:0] pressed_next;
   logic             lp_p;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
         debounce_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_chan (
            .clk           (clk_clk),
            .rst           (reset_reset),
            .raw           (key_raw[gi]),
            .level         (key_level[gi]),
            .level_next    (level_next[gi]),
            .press_pulse   (key_press_pulse[gi]),
            .release_pulse (key_release_pulse[gi])
         );
      end
   endgenerate

   // The FSM follows the debounced level as it is being accepted, so HOLD
   // starts in the same cycle as the press pulse on the monitored key.
   assign pressed_next = level_next ^ {WIDTH{IDLE_LVL}};
   assign lp_p         = |(pressed_next & LP_MASK);

   lp_state_t     state_reg, state_next;
   logic [LW-1:0] lp_cnt_reg, lp_cnt_next;
   logic [PW-1:0] pc_reg, pc_next;
   logic          lp_holding_reg, req_n_reg;

   always_comb begin
      state_next  = state_reg;
      lp_cnt_next = lp_cnt_reg;
      pc_next     = pc_reg;
      case (state_reg)
         IDLE: begin
            if (lp_p) begin
               state_next  = HOLD;
               lp_cnt_next = '0;
            end
         end
         HOLD: begin
            if (!lp_p) begin
               state_next = IDLE;
            end else if (lp_cnt_reg == LP_LAST) begin
               state_next = FIRE;
               pc_next    = '0;
            end else begin
               lp_cnt_next = lp_cnt_reg + 1'b1;
            end
         end
         FIRE: begin
            // A release here must not cut the request short.
            if (pc_reg == PC_LAST) begin
               state_next = WAIT_REL;
            end else begin
               pc_next = pc_reg + 1'b1;
            end
         end
         WAIT_REL: begin
            if (!lp_p) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_reg      <= IDLE;
         lp_cnt_reg     <= '0;
         pc_reg         <= '0;
         lp_holding_reg <= 1'b0;
         req_n_reg      <= 1'b1;
      end else begin
         state_reg      <= state_next;
         lp_cnt_reg     <= lp_cnt_next;
         pc_reg         <= pc_next;
         lp_holding_reg <= (state_next == HOLD);
         req_n_reg      <= (state_next != FIRE);
      end
   end

   assign lp_holding       = lp_holding_reg;
   assign warm_reset_req_n = req_n_reg;

endmodule
